// File: rtl/vend_controller.sv
// vend_controller: vending command sequencer with credit, stock, dispense and refund handling
module vend_controller #(
  parameter int CREDIT_W = 8,
  parameter int PRICE0 = 3,
  parameter int PRICE1 = 5,
  parameter int PRICE2 = 7,
  parameter int PRICE3 = 10,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [1:0]          item_type,
  input  logic [3:0]          number,
  input  logic                cancel,
  output logic                busy,
  output logic                dispense,
  output logic [1:0]          dispense_type,
  output logic                done,
  output logic [1:0]          err,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid
);
  localparam int CW = CREDIT_W + 4;
  typedef enum logic [2:0] {IDLE, CHARGE, CHECK, DISPENSE, REFUND, FINISH} state_t;
  state_t state, state_n;
  logic [1:0] type_r, err_r, err_n, chk_err;
  logic [3:0] num_r, cnt, cnt_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [STOCK_W-1:0] stock [4];
  logic [CREDIT_W:0] sum;
  logic [CW-1:0] price_sel, cost;
  assign sum = {1'b0, credit} + (CREDIT_W+1)'(num_r);
  assign price_sel = type_r == 2'd0 ? CW'(PRICE0) : type_r == 2'd1 ? CW'(PRICE1) :
                     type_r == 2'd2 ? CW'(PRICE2) : CW'(PRICE3);
  assign cost = price_sel * CW'(num_r);
  assign chk_err = num_r == 4'd0 ? 2'b11 :
                   32'(stock[type_r]) < 32'(num_r) ? 2'b10 :
                   cost > CW'(credit) ? 2'b01 : 2'b00;
  always_comb begin
    state_n = state;
    credit_n = credit;
    err_n = err_r;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = start ? (mode ? CHARGE : CHECK) : cancel ? REFUND : IDLE;
      CHARGE: begin
        err_n = sum[CREDIT_W] ? 2'b11 : 2'b00;
        credit_n = sum[CREDIT_W] ? credit : sum[CREDIT_W-1:0];
        state_n = FINISH;
      end
      CHECK: begin
        err_n = chk_err;
        credit_n = chk_err == 2'b00 ? credit - cost[CREDIT_W-1:0] : credit;
        cnt_n = num_r;
        state_n = chk_err == 2'b00 ? DISPENSE : FINISH;
      end
      DISPENSE: begin
        cnt_n = cnt - 4'd1;
        state_n = cnt == 4'd1 ? FINISH : DISPENSE;
      end
      REFUND: begin
        err_n = 2'b00;
        credit_n = '0;
        state_n = FINISH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      credit <= '0;
      err_r <= 2'b00;
      cnt <= 4'd0;
      type_r <= 2'd0;
      num_r <= 4'd0;
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state <= state_n;
      credit <= credit_n;
      err_r <= err_n;
      cnt <= cnt_n;
      if (state == IDLE && start) begin
        type_r <= item_type;
        num_r <= number;
      end
      if (state == DISPENSE) stock[type_r] <= stock[type_r] - STOCK_W'(1);
    end
  end
  assign busy = state != IDLE;
  assign dispense = state == DISPENSE;
  assign dispense_type = type_r;
  assign done = state == FINISH;
  assign err = done ? err_r : 2'b00;
  assign change_valid = state == REFUND;
  assign change = change_valid ? credit : '0;
endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Top-level sequencer for the vending machine datapath.
- Accepts charge and purchase commands (mode/type/number), keeps the customer credit balance and per-product stock counts, and issues one dispense pulse per item.
- Ends every command with a done pulse and a status code; a cancel request returns the remaining credit as change.
- Sits between the front-panel input logic and the dispense/charge datapath.

Parameters:
- CREDIT_W, 8: credit register width, in credit units.
- PRICE0, 3: unit price of product type 0.
- PRICE1, 5: unit price of product type 1.
- PRICE2, 7: unit price of product type 2.
- PRICE3, 10: unit price of product type 3.
- STOCK_W, 4: width of each per-type stock counter.
- INIT_STOCK, 5: value loaded into every stock counter at reset.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high; clears all state at the next clk edge.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  1 = charge, 0 = purchase; latched with start.
- type  in  2  product select 0..3; latched with start.
- number  in  4  charge amount (charge mode) or item quantity (purchase mode); latched with start.
- cancel  in  1  refund request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- dispense  out  1  one-cycle pulse per item released.
- dispense_type  out  2  product of the current dispense pulse; holds the latched type.
- done  out  1  one-cycle pulse at command completion.
- err  out  2  status, valid while done=1: 00 ok, 01 insufficient credit, 10 out of stock, 11 invalid (zero quantity or credit overflow).
- credit  out  CREDIT_W  current balance, registered.
- change  out  CREDIT_W  refund amount, valid while change_valid=1.
- change_valid  out  1  one-cycle refund pulse.

Behaviour:
- Reset values: state=IDLE, credit=0, every stock counter=INIT_STOCK, item counter=0, all outputs 0.
  - Reset during any state, including mid-dispense, aborts the command.
  - No done pulse is issued for the aborted command.
- FSM states: IDLE, CHARGE, CHECK, DISPENSE, REFUND, FINISH.
- IDLE:
  - start=1 latches mode, type and number.
  - mode=1 goes to CHARGE; mode=0 goes to CHECK.
  - cancel=1 with start=0 goes to REFUND.
  - start has priority over cancel in the same cycle.
  - cancel or start in any non-IDLE state is ignored; there is no queueing.
- CHARGE (1 cycle):
  - Sum is formed at CREDIT_W+1 bits.
  - If credit+number > 2^CREDIT_W-1: err=11, credit unchanged.
  - Otherwise credit += number, err=00.
  - number=0 is legal: credit unchanged, err=00.
  - Always goes to FINISH.
- CHECK (1 cycle):
  - cost = PRICE[type]*number, computed at CREDIT_W+4 bits with no truncation.
  - Priority: number=0 gives err=11; else stock[type] < number gives err=10; else cost > credit gives err=01.
  - Any error goes to FINISH with no state change.
  - Pass: credit -= cost, item counter = number, go to DISPENSE.
  - Credit is debited once, up front, in CHECK.
- DISPENSE (exactly number cycles):
  - Each cycle: dispense=1, dispense_type=latched type, stock[type] -= 1, item counter -= 1.
  - When the item counter is 1, the next state is FINISH.
  - Stock never underflows, because CHECK guarantees enough stock.
- REFUND (1 cycle): change=credit, change_valid=1, credit=0, go to FINISH.
  - A refund with credit=0 still pulses change_valid with change=0.
- FINISH (1 cycle): done=1, err driven, go to IDLE. err returns to 00 outside FINISH.
- Latency, with start/cancel sampled in cycle T:
  - Charge, refund and any error: done in cycle T+2.
  - Successful purchase of N items: dispense pulses in T+2..T+1+N, done in T+2+N.
- Back-to-back commands: the earliest next start is accepted in the cycle after done, when the FSM is back in IDLE.
- credit is updated on the clock edge that leaves CHARGE, CHECK or REFUND.

Test Plan:
- Reset, then charge number=15 -> done at T+2, err=00, credit=15, no dispense.
- From credit=15, purchase type=1 number=2 -> cost 10; two consecutive dispense pulses, dispense_type=1; done at T+4, err=00, credit=5.
  - Then purchase type=1 number=4 -> err=10, because stock1 is now 3.
- From credit=5, purchase type=3 number=1 -> cost 10; err=01 at T+2, no dispense, credit stays 5.
- Purchase type=0 number=6 (stock 5) -> err=10; purchase number=0 -> err=11; credit unchanged in both cases.
- Charge repeatedly to credit=250, then charge number=15 -> err=11, credit stays 250.
  - Then cancel -> change=250 and change_valid for one cycle, credit=0, done at T+2.
- Start a purchase of 3 items and assert reset after the first dispense pulse -> next cycle busy=0, credit=0, all stock counters=5, no done pulse.
  - Start and cancel in the same IDLE cycle -> the command runs, no refund.
